// File: rtl/decode_pipe.sv
// decode_pipe: a binary-to-one-hot decoder behind a 2-entry valid/ready FIFO.
//
// Each accepted {in_sel, in_en} is queued. It appears at the output one
// cycle later as a one-hot word. All outputs are registered, so in_ready
// has no combinational path from out_ready. Because of that, a FULL queue
// refuses a push even in a cycle where it is popped.
//
// Optional feature: define DECODE_PIPE_COUNT_EN to add the dec_count port.
// It is a saturating counter of popped transfers. flush and reset clear it.
//
// Parameters:
//   UUID        - instance identifier (no children to forward it to here)
//   NAME        - instance label, no functional effect
//   SEL_WIDTH   - select width (1..6); OUT_WIDTH = 2**SEL_WIDTH
//   COUNT_WIDTH - dec_count width (1..32)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   in_valid   - producer offers in_sel/in_en
//   in_ready   - block can accept this cycle
//   in_sel     - binary index to decode
//   in_en      - decode enable (0 -> all-zero word)
//   flush      - synchronous discard of all queued entries (highest priority)
//   out_valid  - out_onehot holds a queued result
//   out_ready  - consumer takes the result
//   out_onehot - decoded head entry, zero when out_valid=0
//   dec_count  - pop counter (DECODE_PIPE_COUNT_EN only)
module decode_pipe #(
  parameter int UUID        = 0,
  parameter     NAME        = "",
  parameter int SEL_WIDTH   = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_WIDTH-1:0]        in_sel,
  input  logic                        in_en,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(1<<SEL_WIDTH)-1:0]   out_onehot
`ifdef DECODE_PIPE_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]      dec_count
`endif
);

  localparam int OUT_WIDTH = 1 << SEL_WIDTH;
  localparam int ENT_WIDTH = SEL_WIDTH + 1;  // {en, sel}

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // The identification parameters carry no logic; this block only references them.
  if ((UUID < 0) && ($bits(NAME) == 0)) begin : g_ident
  end

  // One-hot decode of a queued {en, sel} entry.
  function automatic logic [OUT_WIDTH-1:0] f_decode(input logic [ENT_WIDTH-1:0] ent);
    logic [OUT_WIDTH-1:0] word;
    word = '0;
    if (ent[ENT_WIDTH-1]) begin
      word[ent[SEL_WIDTH-1:0]] = 1'b1;
    end else begin
      word = '0;
    end
    return word;
  endfunction

  occ_t                 r_occ;
  logic [ENT_WIDTH-1:0] r_e0;   // head
  logic [ENT_WIDTH-1:0] r_e1;   // second entry, valid only in FULL
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_onehot;

  occ_t                 w_occ_nxt;
  logic [ENT_WIDTH-1:0] w_e0_nxt;
  logic [ENT_WIDTH-1:0] w_e1_nxt;
  logic [ENT_WIDTH-1:0] w_new;
  logic                 w_push;
  logic                 w_pop;

  assign w_new  = {in_en, in_sel};
  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Next occupancy and entry contents; flush overrides any push or pop.
  always_comb begin
    w_occ_nxt = r_occ;
    w_e0_nxt  = r_e0;
    w_e1_nxt  = r_e1;
    if (flush) begin
      w_occ_nxt = EMPTY;
    end else begin
      case (r_occ)
        EMPTY: begin
          if (w_push) begin
            w_occ_nxt = ONE;
            w_e0_nxt  = w_new;
          end else begin
            w_occ_nxt = EMPTY;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            // The head leaves and the new entry takes its place.
            w_e0_nxt = w_new;
          end else if (w_push) begin
            w_occ_nxt = FULL;
            w_e1_nxt  = w_new;
          end else if (w_pop) begin
            w_occ_nxt = EMPTY;
          end else begin
            w_occ_nxt = ONE;
          end
        end
        FULL: begin
          // in_ready is low in FULL, so only a pop can happen here.
          if (w_pop) begin
            w_occ_nxt = ONE;
            w_e0_nxt  = r_e1;
          end else begin
            w_occ_nxt = FULL;
          end
        end
        default: begin
          w_occ_nxt = EMPTY;
        end
      endcase
    end
  end

  // State and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ        <= EMPTY;
      r_e0         <= '0;
      r_e1         <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_onehot <= '0;
    end else begin
      r_occ        <= w_occ_nxt;
      r_e0         <= w_e0_nxt;
      r_e1         <= w_e1_nxt;
      r_in_ready   <= (w_occ_nxt != FULL);
      r_out_valid  <= (w_occ_nxt != EMPTY);
      r_out_onehot <= (w_occ_nxt != EMPTY) ? f_decode(w_e0_nxt) : '0;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_onehot = r_out_onehot;

`ifdef DECODE_PIPE_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_dec_count;

  // Saturating pop counter; a flush cancels the same-cycle pop and clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dec_count <= '0;
    end else if (flush) begin
      r_dec_count <= '0;
    end else if (w_pop && (r_dec_count != '1)) begin
      r_dec_count <= r_dec_count + COUNT_WIDTH'(1);
    end else begin
      r_dec_count <= r_dec_count;
    end
  end

  assign dec_count = r_dec_count;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe (SEL_WIDTH=4, COUNT_WIDTH=2).
module tb_decode_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic        in_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_onehot;
`ifdef DECODE_PIPE_COUNT_EN
  logic [1:0]  dec_count;
`endif

  int n_checks;
  int n_errors;

  decode_pipe #(
    .UUID        (0),
    .NAME        ("dut"),
    .SEL_WIDTH   (4),
    .COUNT_WIDTH (2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_en      (in_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot)
`ifdef DECODE_PIPE_COUNT_EN
    ,
    .dec_count  (dec_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [3:0]  sel;
    logic        en;
    logic        ordy;
    logic        fl;
    logic        exp_ir;
    logic        exp_ov;
    logic [15:0] exp_oh;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] sel, input logic en,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_sel    = sel;
    in_en     = en;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic chk_cnt(input string name, input logic [1:0] exp);
`ifdef DECODE_PIPE_COUNT_EN
    chk(name, {30'd0, dec_count}, {30'd0, exp});
`endif
  endtask

  function automatic vec_t mk(input string name, input logic v, input logic [3:0] sel,
                              input logic en, input logic ordy, input logic fl,
                              input logic ir, input logic ov, input logic [15:0] oh,
                              input logic [1:0] cnt);
    vec_t r;
    r.name = name; r.v = v; r.sel = sel; r.en = en; r.ordy = ordy; r.fl = fl;
    r.exp_ir = ir; r.exp_ov = ov; r.exp_oh = oh; r.exp_cnt = cnt;
    return r;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;

    //                 name          v     sel    en    ordy  fl    ir    ov    onehot      cnt
    vecs[0]  = mk("push5",       1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 2'd0);
    vecs[1]  = mk("pop5",        1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1);
    vecs[2]  = mk("push3",       1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0008, 2'd1);
    vecs[3]  = mk("push9_full",  1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 2'd1);
    vecs[4]  = mk("refuse12",    1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 2'd1);
    vecs[5]  = mk("pop3",        1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 2'd2);
    vecs[6]  = mk("pop9",        1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3);
    vecs[7]  = mk("flush_idle",  1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0);
    vecs[8]  = mk("push7_en0",   1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 2'd0);
    vecs[9]  = mk("pop7",        1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1);
    vecs[10] = mk("push1",       1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 2'd1);
    vecs[11] = mk("pushpop2",    1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 2'd2);
    vecs[12] = mk("push15_full", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 2'd2);
    vecs[13] = mk("flush_full",  1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0);
    vecs[14] = mk("idle",        1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0);

    // Reset state.
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_onehot",    {16'd0, out_onehot}, 32'd0);
    chk_cnt("rst_count", 2'd0);
    #2 rst = 1'b1;
    step();
    chk("release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Table-driven per-cycle vectors.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].en, vecs[i].ordy, vecs[i].fl);
      step();
      chk({vecs[i].name, "_in_ready"},  {31'd0, in_ready},   {31'd0, vecs[i].exp_ir});
      chk({vecs[i].name, "_out_valid"}, {31'd0, out_valid},  {31'd0, vecs[i].exp_ov});
      chk({vecs[i].name, "_onehot"},    {16'd0, out_onehot}, {16'd0, vecs[i].exp_oh});
      chk_cnt({vecs[i].name, "_count"}, vecs[i].exp_cnt);
    end

    // Five transfers with a 2-bit counter: 1, 2, 3, 3, 3.
    for (int i = 0; i < 5; i++) begin
      logic [15:0] exp_oh;
      logic [1:0]  exp_c;
      exp_oh = 16'h0001 << i;
      exp_c  = (i >= 2) ? 2'd3 : 2'(i + 1);
      drive(1'b1, 4'(i + 4), 1'b1, 1'b0, 1'b0);
      step();
      exp_oh = 16'h0001 << (i + 4);
      chk("sat_push_onehot", {16'd0, out_onehot}, {16'd0, exp_oh});
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      step();
      chk("sat_pop_valid", {31'd0, out_valid}, 32'd0);
      chk_cnt("sat_count", exp_c);
    end

    // Asynchronous reset pulse while ONE, between clock edges.
    drive(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    step();
    chk("pre_rst_onehot", {16'd0, out_onehot}, 32'h0040);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_in_ready",  {31'd0, in_ready},   32'd0);
    chk("async_out_valid", {31'd0, out_valid},  32'd0);
    chk("async_onehot",    {16'd0, out_onehot}, 32'd0);
    chk_cnt("async_count", 2'd0);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("post_rst_no_stale",  {31'd0, out_valid}, 32'd0);
    chk("post_rst_onehot",    {16'd0, out_onehot}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
